alu_pipe: RTL and testbench

//  Parametrised, handshaked successor to the combinational 32-bit ALU (AND/XOR/ADD/SUB).

---
 rtl/alu_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU stage: single-cycle logic/arith ops, bit-serial logical shifts,
// result and status flags held on a valid/ready output until consumed.
module alu_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_XOR = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             shl_q, shl_d;

    logic             accept_c;
    logic             is_sub_c;
    logic             is_shift_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] b_op_c;
    logic [WIDTH:0]   sum_c;
    logic             ovf_c;
    logic [WIDTH-1:0] res_y_c;
    logic             res_carry_c;
    logic             res_ovf_c;
    logic [WIDTH-1:0] step_y_c;
    logic             step_carry_c;

    assign accept_c   = in_valid && (state_q == S_IDLE);
    assign is_sub_c   = (op == OP_SUB) || (op == OP_SLT);
    assign is_shift_c = (op == OP_SHL) || (op == OP_SHR);
    assign shamt_c    = b[SHW-1:0];

    // Shared adder: subtraction as a + ~b + 1
    assign b_op_c = is_sub_c ? ~b : b;
    assign sum_c  = {1'b0, a} + {1'b0, b_op_c} + (WIDTH+1)'(is_sub_c);
    assign ovf_c  = (a[WIDTH-1] == b_op_c[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);

    // Result selection at accept; shifts start from a and iterate in SHIFT
    always_comb begin
        res_y_c     = a;
        res_carry_c = 1'b0;
        res_ovf_c   = 1'b0;
        case (op)
            OP_AND: res_y_c = a & b;
            OP_XOR: res_y_c = a ^ b;
            OP_OR:  res_y_c = a | b;
            OP_ADD: begin
                res_y_c     = sum_c[WIDTH-1:0];
                res_carry_c = sum_c[WIDTH];
                res_ovf_c   = ovf_c;
            end
            OP_SUB: begin
                res_y_c     = sum_c[WIDTH-1:0];
                res_carry_c = ~sum_c[WIDTH];
                res_ovf_c   = ovf_c;
            end
            OP_SLT: begin
                res_y_c     = {{(WIDTH-1){1'b0}}, sum_c[WIDTH-1] ^ ovf_c};
                res_carry_c = ~sum_c[WIDTH];
                res_ovf_c   = ovf_c;
            end
            default: res_y_c = a;
        endcase
    end

    // One-bit shift step with zero fill; the bit leaving y becomes carry
    always_comb begin
        if (shl_q) begin
            step_y_c     = {y_q[WIDTH-2:0], 1'b0};
            step_carry_c = y_q[WIDTH-1];
        end else begin
            step_y_c     = {1'b0, y_q[WIDTH-1:1]};
            step_carry_c = y_q[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = (is_shift_c && (shamt_c != '0)) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    // Datapath next-state: load at accept, step while shifting, hold otherwise
    always_comb begin
        y_d     = y_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        shl_d   = shl_q;
        if (accept_c) begin
            y_d     = res_y_c;
            zero_d  = (res_y_c == '0);
            neg_d   = res_y_c[WIDTH-1];
            carry_d = res_carry_c;
            ovf_d   = res_ovf_c;
            cnt_d   = shamt_c;
            shl_d   = (op == OP_SHL);
        end else if (state_q == S_SHIFT) begin
            y_d     = step_y_c;
            zero_d  = (step_y_c == '0);
            neg_d   = step_y_c[WIDTH-1];
            carry_d = step_carry_c;
            cnt_d   = cnt_q - SHW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            shl_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            shl_q   <= shl_d;
        end
    end

    assign y        = y_q;
    assign zero     = zero_q;
    assign negative = neg_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, backpressure and reset-abort sequences,
// and a randomized run, all checked through an expected-result queue.
module tb_alu_pipe;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         busy;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         zf;
        logic         nf;
        logic         cf;
        logic         vf;
        int           lat;
        int           acc;
    } vec_t;

    vec_t sb_q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   rdy_mode = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                input logic [W-1:0] yy, input logic z, input logic n,
                                input logic c, input logic v, input int lat);
        vec_t r;
        r.op = o; r.a = aa; r.b = bb; r.y = yy;
        r.zf = z; r.nf = n; r.cf = c; r.vf = v; r.lat = lat; r.acc = 0;
        return r;
    endfunction

    // Reference model written from the operation definitions, not the adder structure
    function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        vec_t r;
        logic [W:0] s;
        longint sa, sbv, d;
        int n;
        r = mk(o, aa, bb, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        sa  = longint'(signed'(aa));
        sbv = longint'(signed'(bb));
        n   = int'(bb[4:0]);
        case (o)
            3'd0: r.y = aa & bb;
            3'd1: r.y = aa ^ bb;
            3'd4: r.y = aa | bb;
            3'd2: begin
                s = {1'b0, aa} + {1'b0, bb};
                r.y = s[W-1:0]; r.cf = s[W];
                d = sa + sbv;
                r.vf = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            3'd3, 3'd5: begin
                d = sa - sbv;
                r.cf = (aa < bb);
                r.vf = (d > 64'sd2147483647) || (d < -64'sd2147483648);
                r.y = (o == 3'd3) ? (aa - bb) : ((sa < sbv) ? 32'd1 : 32'd0);
            end
            3'd6: begin
                r.y = aa << n; r.cf = (n > 0) ? aa[W-n] : 1'b0; r.lat = 1 + n;
            end
            default: begin
                r.y = aa >> n; r.cf = (n > 0) ? aa[n-1] : 1'b0; r.lat = 1 + n;
            end
        endcase
        r.zf = (r.y == '0);
        r.nf = r.y[W-1];
        return r;
    endfunction

    // out_ready driver: 0 = always ready, 1 = random, 2 = held low
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: latency on rising out_valid, result/flags on each consume
    always @(negedge clk) begin
        vec_t e;
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb_q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
                else chk("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("y", 64'(y), 64'(e.y));
                chk("flags_zncv", 64'({zero, negative, carry, overflow}), 64'({e.zf, e.nf, e.cf, e.vf}));
            end
            prev_ov <= out_valid;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb, input vec_t e);
        int t = 0;
        vec_t ee = e;
        @(negedge clk);
        in_valid = 1'b1; a = aa; b = bb; op = o;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        ee.acc = cyc;
        sb_q.push_back(ee);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[18];
        vec_t e;
        int seen;
        logic [2:0] ro;
        logic [W-1:0] ra, rb;

        tbl[0]  = mk(3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0, 1);
        tbl[1]  = mk(3'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 0, 1, 1);
        tbl[2]  = mk(3'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 1);
        tbl[3]  = mk(3'd6, 32'h00000003, 32'h0000001F, 32'h80000000, 0, 1, 1, 0, 32);
        tbl[4]  = mk(3'd7, 32'h00000001, 32'h00000000, 32'h00000001, 0, 0, 0, 0, 1);
        tbl[5]  = mk(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 0, 1);
        tbl[6]  = mk(3'd1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1, 0, 0, 0, 1);
        tbl[7]  = mk(3'd4, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 0, 1);
        tbl[8]  = mk(3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1, 1);
        tbl[9]  = mk(3'd3, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 1, 1, 0, 1);
        tbl[10] = mk(3'd5, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 1, 1);
        tbl[11] = mk(3'd5, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 1, 1, 1);
        tbl[12] = mk(3'd7, 32'h80000000, 32'h00000004, 32'h08000000, 0, 0, 0, 0, 5);
        tbl[13] = mk(3'd7, 32'h0000000F, 32'h00000002, 32'h00000003, 0, 0, 1, 0, 3);
        tbl[14] = mk(3'd6, 32'h00000001, 32'h00000001, 32'h00000002, 0, 0, 0, 0, 2);
        tbl[15] = mk(3'd3, 32'h00000003, 32'h00000003, 32'h00000000, 1, 0, 0, 0, 1);
        tbl[16] = mk(3'd7, 32'h00000001, 32'h00000001, 32'h00000000, 1, 0, 1, 0, 2);
        tbl[17] = mk(3'd6, 32'hFFFFFFFF, 32'h00000023, 32'hFFFFFFF8, 0, 1, 1, 0, 4);

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({y, out_valid, busy, in_ready, zero, negative, carry, overflow}),
            64'({32'h0, 1'b0, 1'b0, 1'b1, 4'b0000}));
        rst = 1'b0;

        // Directed vectors, consumer always ready
        for (int i = 0; i < 18; i++) issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i]);
        drain();

        // Backpressure: result held 5 cycles, in_valid pulses while not ready are dropped
        rdy_mode = 2;
        @(posedge clk); #2;
        issue(3'd2, 32'h7FFFFFFF, 32'h00000001, tbl[8]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_y", 64'(y), 64'h80000000);
            chk("bp_hold_state", 64'({out_valid, in_ready, busy, zero, negative, carry, overflow}),
                64'({1'b1, 1'b0, 1'b1, 4'b0101}));
            in_valid = (i % 2 == 0); op = 3'd0; a = '0; b = '0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        chk("bp_released_idle", 64'({in_ready, out_valid, busy}), 64'({1'b1, 1'b0, 1'b0}));
        issue(3'd1, 32'h0F0F0F0F, 32'hFFFFFFFF, mk(3'd1, 0, 0, 32'hF0F0F0F0, 0, 1, 0, 0, 1));
        drain();

        // Reset mid-shift aborts the operation
        issue(3'd6, 32'h00000001, 32'h0000000A, mk(3'd6, 0, 0, 32'h00000400, 0, 0, 0, 0, 11));
        repeat (4) @(negedge clk);
        chk("mid_shift_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_reset_outputs", 64'({y, out_valid, busy, in_ready, zero, negative, carry, overflow}),
            64'({32'h0, 1'b0, 1'b0, 1'b1, 4'b0000}));
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_valid_after_abort", 64'(seen), 64'd0);
        issue(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, tbl[5]);
        drain();

        // Randomized ops with input gaps and output stalls
        rdy_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'hFFFFFFFF;
                2:       ra = 32'h7FFFFFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            e = model(ro, ra, rb);
            issue(ro, ra, rb, e);
        end
        drain();
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
